// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with subtractive reset; define REFRACTORY_EN to add a post-spike refractory period
module lif_neuron #(
  parameter int MEM_W = 16,
  parameter int IN_W = 8,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              beta_sel,
  input  logic                    leak_tick,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_current,
  input  logic [MEM_W-2:0]        threshold,
  output logic                    spike_out,
  output logic signed [MEM_W-1:0] mem_out
);
  localparam int SW = MEM_W + 2;
  localparam logic [1:0] ACTIVE = 2'd0, FIRE = 2'd1, REFRAC = 2'd2;
  localparam logic signed [SW-1:0] MAX_V = {3'b000, {(MEM_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {3'b111, {(MEM_W-1){1'b0}}};
  logic [1:0] state_q, state_d;
  logic signed [MEM_W-1:0] mem_q, mem_d, shr, leak, thr;
  logic signed [IN_W-1:0] cur;
  logic signed [SW-1:0] acc, sub;
  logic spike_q, spike_d, ready_q, ready_d, fire;
`ifdef REFRACTORY_EN
  localparam int CW = $clog2(REFRAC_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  localparam int unused_refrac_cycles = REFRAC_CYCLES;
`endif

  function automatic logic signed [MEM_W-1:0] sat(input logic signed [SW-1:0] v);
    return v > MAX_V ? MAX_V[MEM_W-1:0] : v < MIN_V ? MIN_V[MEM_W-1:0] : v[MEM_W-1:0];
  endfunction

  // firing is judged on the settled membrane, so a residual left by the subtraction can fire again
  always_comb begin
    thr = {1'b0, threshold};
    cur = in_valid && ready_q ? in_current : '0;
    shr = mem_q >>> ({1'b0, beta_sel} + 3'd2);
    leak = leak_tick ? shr : '0;
    acc = SW'(mem_q) - SW'(leak) + SW'(cur);
    sub = SW'(mem_q) - SW'(thr);
    fire = |threshold && mem_q >= thr;
    mem_d = state_q == FIRE ? sat(sub) : sat(acc);
`ifdef REFRACTORY_EN
    state_d = state_q == ACTIVE ? (fire ? FIRE : ACTIVE) :
              state_q == FIRE ? REFRAC : (cnt_q == '0 ? ACTIVE : REFRAC);
    cnt_d = state_q == FIRE ? CW'(REFRAC_CYCLES - 1) :
            state_q == REFRAC && cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
`else
    state_d = state_q == ACTIVE && fire ? FIRE : ACTIVE;
`endif
    spike_d = state_d == FIRE;
    ready_d = state_d == ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACTIVE;
      mem_q <= '0;
      spike_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mem_q <= mem_d;
      spike_q <= spike_d;
      ready_q <= ready_d;
    end
  end

`ifdef REFRACTORY_EN
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif

  assign in_ready = ready_q;
  assign spike_out = spike_q;
  assign mem_out = mem_q;
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: scoreboard bench for lif_neuron with an arithmetic reference model
module tb_lif_neuron;
`ifdef REFRACTORY_EN
  localparam int R = 4;
`else
  localparam int R = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, leak_tick = 1'b0, in_valid = 1'b0;
  logic [1:0] beta_sel = 2'd0;
  logic signed [7:0] in_current = '0;
  logic [14:0] threshold = '0;
  logic in_ready, spike_out;
  logic signed [15:0] mem_out;

  lif_neuron #(.MEM_W(16), .IN_W(8), .REFRAC_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .beta_sel(beta_sel), .leak_tick(leak_tick),
    .in_valid(in_valid), .in_ready(in_ready), .in_current(in_current),
    .threshold(threshold), .spike_out(spike_out), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  typedef struct {int mem; bit spike; bit ready;} exp_t;
  exp_t sbq[$];
  int pass_cnt = 0, total_cnt = 0;
  int m_mem = 0, m_busy = 0;
  bit m_spike = 0;

  function automatic void chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic int clamp(int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  function automatic int fdiv(int a, int d);
    return a >= 0 ? a / d : -((-a + d - 1) / d);
  endfunction

  // m_busy counts cycles left in which the neuron refuses input
  task automatic model(input bit rst, input int k, input bit lk, input bit vld, input int cur, input int thr);
    int nxt;
    bit f;
    exp_t e;
    if (rst) begin
      m_mem = 0; m_busy = 0; m_spike = 0;
    end else if (m_spike) begin
      m_mem = clamp(m_mem - thr); m_spike = 0; m_busy--;
    end else begin
      nxt = m_mem - (lk ? fdiv(m_mem, 1 << k) : 0) + ((m_busy == 0 && vld) ? cur : 0);
      f = m_busy == 0 && thr != 0 && m_mem >= thr;
      if (m_busy > 0) m_busy--;
      m_mem = clamp(nxt);
      if (f) begin m_spike = 1; m_busy = 1 + R; end
    end
    e.mem = m_mem; e.spike = m_spike; e.ready = (m_busy == 0);
    sbq.push_back(e);
  endtask

  task automatic step(input bit rst, input int bs, input bit lk, input bit vld, input int cur, input int thr);
    reset = rst; beta_sel = bs[1:0]; leak_tick = lk; in_valid = vld;
    in_current = cur[7:0]; threshold = thr[14:0];
    model(rst, bs + 2, lk, vld, cur, thr);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_mem", mem_out, e.mem);
      chk("sb_spike", spike_out, e.spike);
      chk("sb_ready", in_ready, e.ready);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int zeros, thr;
    bit done, rdy, lk;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_mem", mem_out, 0);
    chk("reset_spike", spike_out, 0);
    chk("reset_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 40, 100);
    chk("t1_mem120", mem_out, 120);
    step(0, 0, 0, 0, 0, 100);
    chk("t1_spike", spike_out, 1);
    chk("t1_ready_low", in_ready, 0);
    step(0, 0, 0, 0, 0, 100);
    chk("t1_residual", mem_out, 20);
    chk("t1_spike_end", spike_out, 0);
    step(0, 0, 0, 1, 60, 100);
    step(0, 3, 1, 0, 0, 100);
    chk("t2_leak_k5", mem_out, 78);
    step(0, 0, 1, 0, 0, 100);
    chk("t2_leak_k2", mem_out, 59);
    step(0, 0, 0, 1, 21, 100);
    step(0, 0, 1, 1, 10, 100);
    chk("t3_leak_plus_in", mem_out, 70);
    step(0, 0, 0, 1, -71, 100);
    step(0, 0, 1, 0, 0, 100);
    chk("t3_minus1_decay", mem_out, 0);
    for (int i = 0; i < 260; i++) step(0, 0, 0, 1, 127, 0);
    chk("t4_sat_pos", mem_out, 32767);
    chk("t4_no_spike", spike_out, 0);
    for (int i = 0; i < 520; i++) step(0, 0, 0, 1, -128, 0);
    chk("t4_sat_neg", mem_out, -32768);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 60, 50);
    step(0, 0, 0, 0, 0, 50);
    chk("t5_spike", spike_out, 1);
    zeros = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = in_ready;
      lk = zeros == 1 && !rdy;
      step(0, 0, lk, 1, 5, 50);
`ifdef REFRACTORY_EN
      if (lk) chk("t5_refrac_leak", mem_out, 8);
`endif
      if (rdy) done = 1;
      else zeros++;
    end
    chk("t5_ready_low_cycles", zeros, R + 1);
    chk("t5_accepted", done, 1);
    chk("t5_mem_after_accept", mem_out, R > 0 ? 13 : 15);
    step(0, 0, 0, 0, 0, 50);
    step(1, 0, 0, 0, 0, 50);
    step(0, 0, 0, 1, 60, 50);
    step(0, 0, 0, 0, 0, 50);
    step(1, 0, 0, 0, 0, 50);
    chk("t6_fire_rst_mem", mem_out, 0);
    chk("t6_fire_rst_spike", spike_out, 0);
    chk("t6_fire_rst_ready", in_ready, 1);
    step(0, 0, 0, 1, 30, 50);
    chk("t6_after_rst", mem_out, 30);
    step(0, 0, 0, 1, 30, 50);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 50);
    step(1, 0, 0, 0, 0, 50);
    chk("t6_refrac_rst_mem", mem_out, 0);
    chk("t6_refrac_rst_ready", in_ready, 1);
    step(0, 0, 0, 1, 30, 50);
    chk("t6_refrac_after_rst", mem_out, 30);
    thr = 120;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) thr = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, 400));
      step($urandom_range(0, 99) == 0, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 6, int'($urandom_range(0, 255)) - 128, thr);
    end
    step(0, 0, 0, 0, 0, thr);
    @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
